mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of the EX/MEM pipeline register. It resolves conditional branches, performs RV32I loads and stores through a ready/valid data-memory port, and stalls the pipeline while memory is busy. It also owns the MEM/WB pipeline register feeding write-back.

## Interface
- TIMEOUT, 16: maximum cycles a memory access may wait for `dmem_ready` (only used with `MEM_TIMEOUT_EN`).
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- RegWrite_i, MemToReg_i, Branch_i, MemRead_i, MemWrite_i  in  1 each  control from EX/MEM
- BA_i  in  32  branch target address
- FlagZero_i  in  1  ALU zero flag
- ALUresult_i  in  32  ALU result / effective address
- rd2_i  in  32  store data
- wr_i  in  5  destination register
- funct3_i  in  3  access size/sign, or branch condition
- dmem_req_o  out  1  memory request valid
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word address (`ALUresult_i` with bits [1:0] = 0)
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned store data
- dmem_rdata_i  in  32  load data, valid when `dmem_ready_i`
- dmem_ready_i  in  1  access complete this cycle
- pcsrc_o  out  1  branch taken
- branch_target_o  out  32  equals `BA_i`
- stall_o  out  1  hold IF/ID/EX and EX/MEM
- misalign_o  out  1  one-cycle pulse on a misaligned access
- bus_err_o  out  1  one-cycle pulse on timeout (tied 0 without the macro)
- mem_wb_RegWrite_o, mem_wb_MemToReg_o  out  1 each  MEM/WB control
- read_data_o  out  32  formatted load data
- ALUresult_o  out  32  forwarded ALU result
- wr_o  out  5  destination register

## Operation
- **Memory op:** `mem_op = MemRead_i | MemWrite_i`.
- **Misalignment:** LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - No request is issued.
  - `misalign_o` pulses.
  - The instruction enters MEM/WB with RegWrite = 0.
  - No stall.
- **States:**
  - IDLE: no access outstanding.
  - WAIT: request issued, `dmem_ready_i` not yet seen.
- **IDLE transitions:**
  - Aligned `mem_op` with `dmem_ready_i` = 1: stay in IDLE; the access completes this cycle.
  - Aligned `mem_op` with `dmem_ready_i` = 0: go to WAIT.
- **WAIT transitions:**
  - `dmem_ready_i` = 1: go to IDLE.
  - Timeout (macro only): go to IDLE.
- **`dmem_req_o`:** high whenever `mem_op` is aligned and not timed out, in either state. Request fields are driven combinationally from the inputs, which upstream holds stable while `stall_o` = 1.
- **`stall_o`:** `dmem_req_o & ~dmem_ready_i`.
- **Stores:**
  - SB: be = 0001 << addr[1:0]; wdata = {4{rd2[7:0]}}.
  - SH: be = 0011 << addr[1:0]; wdata = {2{rd2[15:0]}}.
  - SW: be = 1111.
- **Loads:** `dmem_be_o` = 1111. Data is taken from the lane selected by addr[1:0]:
  - LB and LH are sign-extended.
  - LBU and LHU are zero-extended.
  - LW is passed through.
  - funct3 011/110/111 with MemRead is treated as LW.
- **Branch:** `pcsrc_o = Branch_i & (funct3==000 ? FlagZero_i : funct3==001 ? ~FlagZero_i : 0)`.
  - Purely combinational and independent of stall.
  - Branch and mem_op are never asserted together.
- **MEM/WB register update, when `stall_o` = 0:**
  - Captures RegWrite (cleared on misalign or bus error), MemToReg, formatted load data, ALUresult and wr.
- **MEM/WB register update, when `stall_o` = 1:**
  - `mem_wb_RegWrite_o` is loaded with 0 (bubble).
  - All other MEM/WB fields hold.

## Timing
- **Reset:** every registered output goes to 0 and the state returns to IDLE, including mid-access. On the next access the request is re-issued from IDLE.
- **Zero-wait memory** (ready in the same cycle as req): no stall. Result appears on MEM/WB outputs 1 cycle after the inputs are presented.
- **N-wait memory:** `stall_o` is high for N cycles. MEM/WB captures on the edge ending the cycle in which ready = 1. Total latency is N+1 cycles.
- **Ignored `dmem_ready_i`:** ready asserted while no request is outstanding is ignored.
- **Request stability:** `dmem_req_o` stays high, with all request fields stable, until ready.
- **Counter:** counts cycles spent in WAIT. It saturates at TIMEOUT and is cleared on entering IDLE.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - In WAIT, when the counter reaches TIMEOUT, `bus_err_o` pulses for 1 cycle and the request drops.
  - `stall_o` releases in that same cycle.
  - The instruction enters MEM/WB with RegWrite = 0.
  - The FSM returns to IDLE.
- `MEM_TIMEOUT_EN` undefined:
  - No counter is built; the block waits indefinitely for ready.
  - `bus_err_o` is tied to 0.

## Test plan
- **Reset:** assert `rst` mid-WAIT → all outputs 0, FSM in IDLE, `stall_o` = 0 while rst is high.
- **SB, zero-wait:** SB, addr 0x1003, rd2 = 0x000000A5, ready tied 1 → be = 1000, wdata = 0xA5A5A5A5, no stall, `mem_wb_RegWrite_o` = 0 (RegWrite_i = 0).
- **LH sign-extend, 3 wait cycles:** LH, addr 0x2002, rdata = 0x8001xxxx, ready after 3 cycles → `stall_o` high for 3 cycles, `mem_wb_RegWrite_o` = 0 during the stall, then `read_data_o` = 0xFFFF8001.
- **LW misaligned:** LW, addr 0x3001 → `dmem_req_o` = 0, `misalign_o` 1-cycle pulse, MEM/WB RegWrite = 0, no stall.
- **BNE:** Branch = 1, funct3 = 001, FlagZero = 0, BA = 0x40 → `pcsrc_o` = 1, `branch_target_o` = 0x40. With FlagZero = 1 → `pcsrc_o` = 0.
- **Timeout (macro, TIMEOUT = 16):** ready held 0 → `bus_err_o` pulses after 16 WAIT cycles, stall drops, RegWrite suppressed.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage RV32I pipeline.
//
// Resolves conditional branches, issues RV32I loads/stores on a ready/valid
// data-memory port, stalls the pipeline while memory is busy, and owns the
// MEM/WB pipeline register.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a WAIT-cycle counter aborts an access after TIMEOUT cycles
//               (bus_err_o pulses, the instruction retires with RegWrite = 0)
//   undefined : no counter; the stage waits indefinitely, bus_err_o = 0
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   RegWrite_i .. funct3_i   EX/MEM pipeline register contents
//   dmem_*                   data-memory request / response port
//   pcsrc_o, branch_target_o branch resolution
//   stall_o                  hold IF/ID/EX and EX/MEM
//   misalign_o, bus_err_o    exception pulses
//   mem_wb_*, read_data_o,
//   ALUresult_o, wr_o        MEM/WB pipeline register
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] BA_i,
  input  logic        FlagZero_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] rd2_i,
  input  logic [4:0]  wr_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        pcsrc_o,
  output logic [31:0] branch_target_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_wb_RegWrite_o,
  output logic        mem_wb_MemToReg_o,
  output logic [31:0] read_data_o,
  output logic [31:0] ALUresult_o,
  output logic [4:0]  wr_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic        w_mem_op;
  logic [1:0]  w_off;
  logic [1:0]  w_size;
  logic        w_misalign;
  logic        w_mis_access;
  logic        w_timeout;
  logic        w_req;
  logic        w_stall;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;

  logic        r_RegWrite;
  logic        r_MemToReg;
  logic [31:0] r_read_data;
  logic [31:0] r_ALUresult;
  logic [4:0]  r_wr;

  assign w_mem_op = MemRead_i | MemWrite_i;
  assign w_off    = ALUresult_i[1:0];
  // funct3[1:0] encodes access size for both loads and stores: 00 byte,
  // 01 half, anything else word (covers the 011/110/111 load aliases).
  assign w_size   = funct3_i[1:0];

  always_comb begin
    w_misalign = 1'b0;
    case (w_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_off[0];
      default: w_misalign = |w_off;
    endcase
  end

  assign w_mis_access = w_mem_op & w_misalign;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next_state == S_IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Reset also masks the request so nothing is issued or stalled while rst is high.
  assign w_req   = ~rst & w_mem_op & ~w_misalign & ~w_timeout;
  assign w_stall = w_req & ~dmem_ready_i;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_stall)  w_next_state = S_WAIT;
      S_WAIT:  if (!w_stall) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Store formatting
  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = '0;
    if (MemWrite_i) begin
      case (w_size)
        2'b00: begin
          dmem_be_o    = 4'b0001 << w_off;
          dmem_wdata_o = {4{rd2_i[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = 4'b0011 << w_off;
          dmem_wdata_o = {2{rd2_i[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = rd2_i;
        end
      endcase
    end
  end

  // Load formatting: shift the addressed lane down to bit 0 first
  assign w_lane = dmem_rdata_i >> {w_off, 3'b000};

  always_comb begin
    w_load_data = dmem_rdata_i;
    case (funct3_i)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_data = {24'd0, w_lane[7:0]};
      3'b101:  w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_RegWrite  <= 1'b0;
      r_MemToReg  <= 1'b0;
      r_read_data <= '0;
      r_ALUresult <= '0;
      r_wr        <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_stall) begin
        r_RegWrite <= 1'b0;
      end else begin
        r_RegWrite  <= RegWrite_i & ~w_mis_access & ~w_timeout;
        r_MemToReg  <= MemToReg_i;
        r_read_data <= w_load_data;
        r_ALUresult <= ALUresult_i;
        r_wr        <= wr_i;
      end
    end
  end

  assign dmem_req_o      = w_req;
  assign dmem_we_o       = MemWrite_i;
  assign dmem_addr_o     = {ALUresult_i[31:2], 2'b00};
  assign stall_o         = w_stall;
  assign misalign_o      = ~rst & w_mis_access;
  assign bus_err_o       = w_timeout;

  assign pcsrc_o = Branch_i & ((funct3_i == 3'b000) ? FlagZero_i :
                               (funct3_i == 3'b001) ? ~FlagZero_i : 1'b0);
  assign branch_target_o = BA_i;

  assign mem_wb_RegWrite_o = r_RegWrite;
  assign mem_wb_MemToReg_o = r_MemToReg;
  assign read_data_o       = r_read_data;
  assign ALUresult_o       = r_ALUresult;
  assign wr_o              = r_wr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage: directed scenarios plus
// randomized loads/stores/branches checked against an arithmetic reference.
module tb_mem_stage;

  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        RegWrite_i, MemToReg_i, Branch_i, MemRead_i, MemWrite_i;
  logic [31:0] BA_i;
  logic        FlagZero_i;
  logic [31:0] ALUresult_i, rd2_i;
  logic [4:0]  wr_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o, dmem_rdata_i;
  logic        dmem_ready_i;
  logic        pcsrc_o;
  logic [31:0] branch_target_o;
  logic        stall_o, misalign_o, bus_err_o;
  logic        mem_wb_RegWrite_o, mem_wb_MemToReg_o;
  logic [31:0] read_data_o, ALUresult_o;
  logic [4:0]  wr_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .Branch_i(Branch_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .BA_i(BA_i),
    .FlagZero_i(FlagZero_i), .ALUresult_i(ALUresult_i), .rd2_i(rd2_i),
    .wr_i(wr_i), .funct3_i(funct3_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ready_i(dmem_ready_i),
    .pcsrc_o(pcsrc_o), .branch_target_o(branch_target_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .mem_wb_RegWrite_o(mem_wb_RegWrite_o), .mem_wb_MemToReg_o(mem_wb_MemToReg_o),
    .read_data_o(read_data_o), .ALUresult_o(ALUresult_o), .wr_o(wr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned access_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(input bit store, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic [3:0] be;
    int unsigned off, sz;
    off = addr % 4;
    sz  = access_bytes(f3);
    be  = '0;
    for (int i = 0; i < 4; i++)
      if (!store || (i >= off && i < off + sz)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (access_bytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * (addr % 4))) & 32'hFF;
    h = (rdata >> (8 * (addr % 4))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    RegWrite_i = 0; MemToReg_i = 0; Branch_i = 0; MemRead_i = 0; MemWrite_i = 0;
    BA_i = '0; FlagZero_i = 0; ALUresult_i = '0; rd2_i = '0; wr_i = '0;
    funct3_i = '0; dmem_rdata_i = '0; dmem_ready_i = 0;
  endtask

  // Full load/store transaction; entered just after a rising edge.
  task automatic do_access(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] d, input logic [31:0] rdata,
                           input int unsigned waits, input bit rw, input bit m2r,
                           input logic [4:0] wr, input string tag);
    bit mis;
    int unsigned nw;
    mis = (addr % access_bytes(f3)) != 0;
    nw  = mis ? 0 : waits;
    RegWrite_i = rw; MemToReg_i = m2r; Branch_i = 0;
    MemRead_i = !store; MemWrite_i = store; funct3_i = f3;
    ALUresult_i = addr; rd2_i = d; wr_i = wr;
    dmem_ready_i = (nw == 0);
    dmem_rdata_i = (nw == 0) ? rdata : $urandom;
    for (int c = 0; c <= int'(nw); c++) begin
      @(negedge clk);
      n_checks++;
      if (dmem_req_o !== !mis) begin
        n_fail++; $display("FAIL %s req c%0d: got %b exp %b", tag, c, dmem_req_o, !mis);
      end
      n_checks++;
      if (stall_o !== (!mis && c < int'(nw))) begin
        n_fail++; $display("FAIL %s stall c%0d: got %b exp %b", tag, c, stall_o, (!mis && c < int'(nw)));
      end
      n_checks++;
      if (misalign_o !== mis) begin
        n_fail++; $display("FAIL %s misalign c%0d: got %b exp %b", tag, c, misalign_o, mis);
      end
      if (!mis) begin
        n_checks++;
        if (dmem_addr_o !== (addr & ~32'h3) || dmem_we_o !== store) begin
          n_fail++; $display("FAIL %s addr/we: got %h/%b exp %h/%b", tag, dmem_addr_o, dmem_we_o, addr & ~32'h3, store);
        end
        n_checks++;
        if (dmem_be_o !== ref_be(store, f3, addr)) begin
          n_fail++; $display("FAIL %s be: got %b exp %b", tag, dmem_be_o, ref_be(store, f3, addr));
        end
        if (store) begin
          n_checks++;
          if (dmem_wdata_o !== ref_wdata(f3, d)) begin
            n_fail++; $display("FAIL %s wdata: got %h exp %h", tag, dmem_wdata_o, ref_wdata(f3, d));
          end
        end
      end
      if (c >= 1) begin
        n_checks++;
        if (mem_wb_RegWrite_o !== 1'b0) begin
          n_fail++; $display("FAIL %s bubble c%0d: got %b exp 0", tag, c, mem_wb_RegWrite_o);
        end
      end
      @(posedge clk); #1;
      if (c + 1 == int'(nw)) begin
        dmem_ready_i = 1; dmem_rdata_i = rdata;
      end
    end
    n_checks++;
    if (mem_wb_RegWrite_o !== (rw && !mis) || mem_wb_MemToReg_o !== m2r) begin
      n_fail++; $display("FAIL %s wb ctl: got %b%b exp %b%b", tag, mem_wb_RegWrite_o, mem_wb_MemToReg_o, (rw && !mis), m2r);
    end
    n_checks++;
    if (ALUresult_o !== addr || wr_o !== wr) begin
      n_fail++; $display("FAIL %s wb alu/wr: got %h/%0d exp %h/%0d", tag, ALUresult_o, wr_o, addr, wr);
    end
    if (!store && !mis) begin
      n_checks++;
      if (read_data_o !== ref_load(f3, addr, rdata)) begin
        n_fail++; $display("FAIL %s read_data: got %h exp %h", tag, read_data_o, ref_load(f3, addr, rdata));
      end
    end
    set_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst = 1;
    MemRead_i = 1; funct3_i = 3'b010; ALUresult_i = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stall_o !== 0 || dmem_req_o !== 0 || misalign_o !== 0 || bus_err_o !== 0) begin
      n_fail++; $display("FAIL reset comb: got stall=%b req=%b mis=%b err=%b exp 0", stall_o, dmem_req_o, misalign_o, bus_err_o);
    end
    n_checks++;
    if ({mem_wb_RegWrite_o, mem_wb_MemToReg_o, read_data_o, ALUresult_o, wr_o} !== '0) begin
      n_fail++; $display("FAIL reset wb: got %b %b %h %h %0d exp all 0", mem_wb_RegWrite_o, mem_wb_MemToReg_o, read_data_o, ALUresult_o, wr_o);
    end
    set_idle();
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_sb_zero_wait();
    do_access(1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, 0, 5'd0, "sb_zero_wait");
  endtask

  task automatic test_lh_wait3();
    do_access(0, 3'b001, 32'h2002, 32'h0, 32'h8001_1234, 3, 1, 1, 5'd7, "lh_wait3");
  endtask

  task automatic test_misaligned();
    do_access(0, 3'b010, 32'h3001, 32'h0, 32'hDEAD_BEEF, 0, 1, 1, 5'd9, "lw_misaligned");
    do_access(1, 3'b001, 32'h3005, 32'h1234, 32'h0, 0, 1, 0, 5'd3, "sh_misaligned");
    @(negedge clk);
    n_checks++;
    if (misalign_o !== 0) begin
      n_fail++; $display("FAIL misalign pulse width: got %b exp 0", misalign_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    logic [2:0] f3;
    bit z, br, exp;
    Branch_i = 1; funct3_i = 3'b001; FlagZero_i = 0; BA_i = 32'h40; #1;
    n_checks++;
    if (pcsrc_o !== 1 || branch_target_o !== 32'h40) begin
      n_fail++; $display("FAIL bne taken: got %b/%h exp 1/00000040", pcsrc_o, branch_target_o);
    end
    FlagZero_i = 1; #1;
    n_checks++;
    if (pcsrc_o !== 0) begin
      n_fail++; $display("FAIL bne not taken: got %b exp 0", pcsrc_o);
    end
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7)); z = 1'($urandom); br = 1'($urandom);
      Branch_i = br; funct3_i = f3; FlagZero_i = z; BA_i = $urandom; #1;
      exp = br && ((f3 == 0 && z) || (f3 == 1 && !z));
      n_checks++;
      if (pcsrc_o !== exp || branch_target_o !== BA_i) begin
        n_fail++; $display("FAIL branch rnd f3=%0d z=%b br=%b: got %b exp %b", f3, z, br, pcsrc_o, exp);
      end
    end
    set_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_random_mem();
    logic [2:0] ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0] f3;
    bit store;
    for (int i = 0; i < 60; i++) begin
      store = 1'($urandom);
      f3 = store ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
      do_access(store, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 5'($urandom), "random");
    end
  endtask

  task automatic test_ignored_ready_and_alu();
    // ready with no request outstanding, on an ALU op with an "odd" address-like result
    RegWrite_i = 1; funct3_i = 3'b010; ALUresult_i = 32'h0000_0013; wr_i = 5'd11;
    dmem_ready_i = 1;
    @(negedge clk);
    n_checks++;
    if (dmem_req_o !== 0 || stall_o !== 0 || misalign_o !== 0) begin
      n_fail++; $display("FAIL ignored ready: got req=%b stall=%b mis=%b exp 0", dmem_req_o, stall_o, misalign_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_wb_RegWrite_o !== 1 || ALUresult_o !== 32'h13 || wr_o !== 5'd11) begin
      n_fail++; $display("FAIL alu passthrough: got %b/%h/%0d exp 1/00000013/11", mem_wb_RegWrite_o, ALUresult_o, wr_o);
    end
    set_idle();
    do_access(0, 3'b100, 32'h0000_0401, 32'h0, 32'h1122_83FF, 1, 1, 1, 5'd4, "lbu_after_ready");
  endtask

  task automatic test_reset_mid_wait();
    RegWrite_i = 1; MemToReg_i = 1; MemRead_i = 1; funct3_i = 3'b010;
    ALUresult_i = 32'h0000_0100; wr_i = 5'd21; dmem_ready_i = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1;
    n_checks++;
    if (stall_o !== 0 || dmem_req_o !== 0) begin
      n_fail++; $display("FAIL reset mid-wait comb: got stall=%b req=%b exp 0/0", stall_o, dmem_req_o);
    end
    n_checks++;
    if ({mem_wb_RegWrite_o, mem_wb_MemToReg_o, read_data_o, ALUresult_o, wr_o} !== '0) begin
      n_fail++; $display("FAIL reset mid-wait wb: got %h %0d exp 0", ALUresult_o, wr_o);
    end
    @(negedge clk);
    rst = 0;
    dmem_ready_i = 1; dmem_rdata_i = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (dmem_req_o !== 1 || stall_o !== 0) begin
      n_fail++; $display("FAIL reissue after reset: got req=%b stall=%b exp 1/0", dmem_req_o, stall_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (read_data_o !== 32'hCAFE_F00D || mem_wb_RegWrite_o !== 1 || wr_o !== 5'd21) begin
      n_fail++; $display("FAIL reissue result: got %h/%b/%0d exp cafef00d/1/21", read_data_o, mem_wb_RegWrite_o, wr_o);
    end
    set_idle();
  endtask

  task automatic test_timeout();
    int stalls;
    bit seen;
    RegWrite_i = 1; MemRead_i = 1; funct3_i = 3'b010; ALUresult_i = 32'h0000_0200;
    wr_i = 5'd2; dmem_ready_i = 0;
    stalls = 0; seen = 0;
`ifdef MEM_TIMEOUT_EN
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus_err_o === 1'b1) begin
        seen = 1;
        n_checks++;
        if (stall_o !== 0 || dmem_req_o !== 0) begin
          n_fail++; $display("FAIL timeout release: got stall=%b req=%b exp 0/0", stall_o, dmem_req_o);
        end
      end else if (stall_o === 1'b1) begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen || stalls != int'(TIMEOUT) + 1) begin
      n_fail++; $display("FAIL timeout: got seen=%b stalls=%0d exp 1/%0d", seen, stalls, TIMEOUT + 1);
    end
    n_checks++;
    if (mem_wb_RegWrite_o !== 0 || wr_o !== 5'd2) begin
      n_fail++; $display("FAIL timeout wb: got %b/%0d exp 0/2", mem_wb_RegWrite_o, wr_o);
    end
    set_idle();
    @(negedge clk);
    n_checks++;
    if (bus_err_o !== 0) begin
      n_fail++; $display("FAIL bus_err pulse width: got %b exp 0", bus_err_o);
    end
    @(posedge clk); #1;
`else
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (stall_o === 1'b1 && bus_err_o === 1'b0) stalls++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (stalls != 24) begin
      n_fail++; $display("FAIL no-timeout wait: got %0d stall cycles exp 24", stalls);
    end
    dmem_ready_i = 1; dmem_rdata_i = 32'h0BAD_CAFE;
    @(posedge clk); #1;
    n_checks++;
    if (mem_wb_RegWrite_o !== 1 || read_data_o !== 32'h0BAD_CAFE) begin
      n_fail++; $display("FAIL no-timeout completion: got %b/%h exp 1/0badcafe", mem_wb_RegWrite_o, read_data_o);
    end
    set_idle();
`endif
  endtask

  initial begin
    test_reset();
    test_sb_zero_wait();
    test_lh_wait3();
    test_misaligned();
    test_branch();
    test_ignored_ready_and_alu();
    test_random_mem();
    test_reset_mid_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
